expand_scheduler: RTL and testbench
===================================

Name: expand_scheduler

Overview:
Frame-based channel sequencer for the single shared EXPAND (log-PCM to linear) resource in the multichannel ADPCM codec. On each 8 kHz frame_sync, it snapshots the enabled-channel mask. It then issues one EXPAND operation per enabled channel in ascending channel order, using a start/done handshake. It reports frame completion and sticky overrun status to the host/control block.

Parameters:
NUM_CH, 32, number of codec channels sharing EXPAND
CH_W, 5, channel index width; must equal clog2(NUM_CH)
TIMEOUT_CYC, 255, watchdog limit in clk cycles per channel (optional feature only)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
frame_sync  input  1  single-cycle pulse at each frame start
ch_enable  input  NUM_CH  per-channel enable; bit i = channel i
ch_law  input  NUM_CH  per-channel law select: 0 = mu-law, 1 = A-law
exp_start  output  1  single-cycle start pulse to EXPAND
exp_ch  output  CH_W  channel index for the current operation; held stable until exp_done
exp_law  output  1  law for the current channel; held stable until exp_done
exp_done  input  1  single-cycle completion pulse from EXPAND
busy  output  1  high from frame acceptance until frame_done
frame_done  output  1  single-cycle pulse when all snapshot channels are serviced
overrun  output  1  sticky flag: frame_sync arrived while busy
overrun_clr  input  1  clears overrun
scan_in0, scan_enable, test_mode  input  1 each  DFT hooks, functionally unused
scan_out0  output  1  DFT hook, tie 0

Behaviour:
- Reset state: state IDLE; pending mask = 0; all outputs = 0 (exp_ch = 0, exp_law = 0, overrun = 0).
- FSM states are IDLE, SCAN, START, WAIT, FDONE.
- IDLE:
  - If frame_sync is high: pending <= ch_enable, law_snap <= ch_law, busy <= 1, go to SCAN.
  - Otherwise: stay in IDLE.
- SCAN:
  - If pending == 0: go to FDONE.
  - Otherwise: exp_ch <= index of the lowest set pending bit, exp_law <= law_snap[index], go to START.
- START:
  - exp_start = 1 for exactly this cycle.
  - Clear pending[exp_ch].
  - Go to WAIT.
- WAIT:
  - On exp_done: go to SCAN.
  - exp_done is sampled only in WAIT and ignored in all other states.
- FDONE:
  - frame_done = 1 for one cycle, busy <= 0, go to IDLE.
- Latency, with frame_sync sampled at edge T:
  - SCAN occupies cycle T+1.
  - exp_start is high in cycle T+2.
  - After exp_done at edge D, the next exp_start is high in cycle D+2.
  - After the last exp_done at edge D, frame_done is high in cycle D+2.
- Empty mask: frame_done pulses in cycle T+2 and exp_start is never issued.
- Snapshot rule: ch_enable and ch_law changes during a frame have no effect until the next accepted frame_sync.
- Overrun:
  - frame_sync in any state other than IDLE sets overrun and is otherwise ignored; the current frame continues.
  - frame_sync in the FDONE cycle counts as overrun.
  - If overrun_clr and a set event occur in the same cycle, set wins.
- Asynchronous reset mid-frame abandons the frame immediately. No frame_done is issued; the EXPAND datapath is reset by the same signal.
- exp_ch and exp_law are registered and change only on the SCAN->START transition.

Optional Feature:
Macro EXPAND_SCHED_TIMEOUT_EN.
- Defined:
  - Add an 8-bit-or-wider watchdog counter, cleared on entry to WAIT.
  - When the count reaches TIMEOUT_CYC without exp_done, the channel is abandoned and the FSM goes to SCAN.
  - Add output err_timeout (1 bit), a sticky flag cleared by overrun_clr, and output err_ch (CH_W bits), which captures the index of the abandoned channel.
- Not defined:
  - No counter is built and the err_timeout/err_ch ports do not exist.
  - WAIT waits indefinitely for exp_done.

Decomposition:
- Package expand_sched_pkg holds:
  - the state enum (IDLE, SCAN, START, WAIT, FDONE);
  - default NUM_CH/CH_W constants;
  - LAW_MU = 0 and LAW_A = 1;
  - the default TIMEOUT_CYC.
- One sub-module, expand_sched_penc: a parameterised lowest-set-bit priority encoder (NUM_CH-bit mask in, CH_W-bit index plus a valid flag out), purely combinational.

Test Plan:
- Basic frame:
  - Stimulus: ch_enable = 0x0000_0005, ch_law = 0x0000_0004; EXPAND model returns exp_done 3 cycles after each start.
  - Response: starts with exp_ch = 0 (exp_law = 0), then exp_ch = 2 (exp_law = 1); frame_done once; busy low afterwards.
- Empty mask:
  - Stimulus: frame_sync with ch_enable = 0.
  - Response: frame_done exactly 2 cycles after frame_sync; no exp_start.
- Full load:
  - Stimulus: ch_enable = 0xFFFF_FFFF.
  - Response: 32 starts with exp_ch in order 0..31; frame_done after the 32nd exp_done.
- Overrun:
  - Stimulus: second frame_sync while in WAIT.
  - Response: overrun = 1; the current frame completes unchanged. overrun_clr then returns overrun to 0.
- Snapshot and stray done:
  - Stimulus: toggle ch_enable mid-frame and pulse exp_done while in SCAN.
  - Response: the channel sequence is unchanged and the stray done is ignored.
- Reset mid-frame (and, with EXPAND_SCHED_TIMEOUT_EN, suppressed done):
  - Stimulus: assert reset while in WAIT.
  - Response: all outputs 0 within the same cycle; no frame_done.
  - With EXPAND_SCHED_TIMEOUT_EN and channel 3's done suppressed: err_timeout = 1, err_ch = 3, and scheduling continues to the next channel.

Source files
------------

// File: rtl/expand_sched_pkg.sv
// Shared types and constants for the EXPAND channel scheduler.
package expand_sched_pkg;

    localparam int NUM_CH_DEF      = 32;
    localparam int CH_W_DEF        = 5;
    localparam int TIMEOUT_CYC_DEF = 255;

    localparam logic LAW_MU = 1'b0;
    localparam logic LAW_A  = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        FDONE = 3'd4
    } state_t;

endpackage

// File: rtl/expand_sched_penc.sv
// Lowest-set-bit priority encoder. Returns the index of the lowest set bit
// of i_mask and a valid flag. Purely combinational.
module expand_sched_penc
    import expand_sched_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CH_W   = CH_W_DEF
) (
    input  logic [NUM_CH-1:0] i_mask,
    output logic [CH_W-1:0]   o_idx,
    output logic              o_valid
);

    logic [NUM_CH-1:0] w_lsb;

    // Isolate the lowest set bit (two's-complement trick), then OR-encode its
    // position; at most one w_lsb bit is set so the OR is a clean encoder.
    always_comb begin
        w_lsb   = i_mask & ((~i_mask) + {{(NUM_CH-1){1'b0}}, 1'b1});
        o_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            o_idx = o_idx | (CH_W'(i) & {CH_W{w_lsb[i]}});
        end
        o_valid = |i_mask;
    end

endmodule

// File: rtl/expand_scheduler.sv
// Frame-based sequencer for the shared EXPAND (log-PCM to linear) resource.
// Each accepted frame_sync snapshots ch_enable/ch_law and issues one EXPAND
// operation per enabled channel, lowest index first.
// Optional build macro: EXPAND_SCHED_TIMEOUT_EN adds a per-channel watchdog
// and the err_timeout / err_ch outputs.
module expand_scheduler
    import expand_sched_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int CH_W        = CH_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_sync,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic [NUM_CH-1:0] ch_law,
    output logic              exp_start,
    output logic [CH_W-1:0]   exp_ch,
    output logic              exp_law,
    input  logic              exp_done,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun,
    input  logic              overrun_clr,
`ifdef EXPAND_SCHED_TIMEOUT_EN
    output logic              err_timeout,
    output logic [CH_W-1:0]   err_ch,
`endif
    input  logic              scan_in0,
    input  logic              scan_enable,
    input  logic              test_mode,
    output logic              scan_out0
);

    state_t            r_state, w_state_nxt;
    logic [NUM_CH-1:0] r_pending, w_pending_nxt;
    logic [NUM_CH-1:0] r_law_snap, w_law_snap_nxt;
    logic [CH_W-1:0]   r_exp_ch, w_exp_ch_nxt;
    logic              r_exp_law, w_exp_law_nxt;
    logic              r_exp_start, w_exp_start_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_frame_done, w_frame_done_nxt;
    logic              r_overrun, w_overrun_nxt;
    logic [CH_W-1:0]   w_penc_idx;
    logic              w_penc_valid;
    logic              w_timeout;
    logic [3:0]        w_dft_unused;

    // DFT hooks are functionally inert.
    assign w_dft_unused = {scan_in0, scan_enable, test_mode, (TIMEOUT_CYC > 0)};
    assign scan_out0    = 1'b0;

    expand_sched_penc #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_penc (
        .i_mask  (r_pending),
        .o_idx   (w_penc_idx),
        .o_valid (w_penc_valid)
    );

`ifdef EXPAND_SCHED_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err_timeout;
    logic [CH_W-1:0] r_err_ch;

    assign w_timeout   = (r_state == WAIT) && !exp_done && (r_wd_cnt == WD_W'(TIMEOUT_CYC));
    assign err_timeout = r_err_timeout;
    assign err_ch      = r_err_ch;

    // Watchdog: restart on entry to WAIT, count while waiting; latch abandoned channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd_cnt      <= '0;
            r_err_timeout <= 1'b0;
            r_err_ch      <= '0;
        end else begin
            if (r_state == START) begin
                r_wd_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_wd_cnt <= r_wd_cnt + {{(WD_W-1){1'b0}}, 1'b1};
            end else begin
                r_wd_cnt <= r_wd_cnt;
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
                r_err_ch      <= r_exp_ch;
            end else if (overrun_clr) begin
                r_err_timeout <= 1'b0;
            end else begin
                r_err_timeout <= r_err_timeout;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; exp_done only matters in WAIT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (frame_sync) w_state_nxt = SCAN;
                else            w_state_nxt = IDLE;
            end
            SCAN: begin
                if (w_penc_valid) w_state_nxt = START;
                else              w_state_nxt = FDONE;
            end
            START:   w_state_nxt = WAIT;
            WAIT: begin
                if (exp_done || w_timeout) w_state_nxt = SCAN;
                else                       w_state_nxt = WAIT;
            end
            FDONE:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values; pulses are pre-decoded from the next
    // state so they appear registered in the cycle the FSM sits in START/FDONE.
    always_comb begin
        w_pending_nxt    = r_pending;
        w_law_snap_nxt   = r_law_snap;
        w_exp_ch_nxt     = r_exp_ch;
        w_exp_law_nxt    = r_exp_law;
        w_busy_nxt       = r_busy;
        w_exp_start_nxt  = (w_state_nxt == START);
        w_frame_done_nxt = (w_state_nxt == FDONE);
        case (r_state)
            IDLE: begin
                if (frame_sync) begin
                    w_pending_nxt  = ch_enable;
                    w_law_snap_nxt = ch_law;
                    w_busy_nxt     = 1'b1;
                end else begin
                    w_busy_nxt     = r_busy;
                end
            end
            SCAN: begin
                if (w_penc_valid) begin
                    w_exp_ch_nxt  = w_penc_idx;
                    w_exp_law_nxt = r_law_snap[w_penc_idx];
                end else begin
                    w_exp_ch_nxt  = r_exp_ch;
                end
            end
            START: begin
                w_pending_nxt[r_exp_ch] = 1'b0;
            end
            FDONE: begin
                w_busy_nxt = 1'b0;
            end
            default: begin
                w_busy_nxt = r_busy;
            end
        endcase
        // Overrun: a frame_sync outside IDLE sets it; set beats clear.
        if (frame_sync && (r_state != IDLE)) begin
            w_overrun_nxt = 1'b1;
        end else if (overrun_clr) begin
            w_overrun_nxt = 1'b0;
        end else begin
            w_overrun_nxt = r_overrun;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending    <= '0;
            r_law_snap   <= '0;
            r_exp_ch     <= '0;
            r_exp_law    <= LAW_MU;
            r_exp_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_pending    <= w_pending_nxt;
            r_law_snap   <= w_law_snap_nxt;
            r_exp_ch     <= w_exp_ch_nxt;
            r_exp_law    <= w_exp_law_nxt;
            r_exp_start  <= w_exp_start_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

    assign exp_start  = r_exp_start;
    assign exp_ch     = r_exp_ch;
    assign exp_law    = r_exp_law;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_expand_scheduler.sv
// Directed self-checking bench for expand_scheduler.
module tb_expand_scheduler;
    import expand_sched_pkg::*;

    localparam int DONE_DLY = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_sync = 1'b0;
    logic [31:0] ch_enable = 32'h0;
    logic [31:0] ch_law = 32'h0;
    logic        exp_start;
    logic [4:0]  exp_ch;
    logic        exp_law;
    logic        exp_done = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        overrun;
    logic        overrun_clr = 1'b0;
    logic        scan_out0;
`ifdef EXPAND_SCHED_TIMEOUT_EN
    logic        err_timeout;
    logic [4:0]  err_ch;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_start;
    int n_fdone;

    always #5 clk = ~clk;

    expand_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .frame_sync  (frame_sync),
        .ch_enable   (ch_enable),
        .ch_law      (ch_law),
        .exp_start   (exp_start),
        .exp_ch      (exp_ch),
        .exp_law     (exp_law),
        .exp_done    (exp_done),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
`ifdef EXPAND_SCHED_TIMEOUT_EN
        .err_timeout (err_timeout),
        .err_ch      (err_ch),
`endif
        .scan_in0    (1'b0),
        .scan_enable (1'b0),
        .test_mode   (1'b0),
        .scan_out0   (scan_out0)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic int lowest(input logic [31:0] m);
        int r;
        r = 32;
        for (int i = 31; i >= 0; i--) begin
            if (m[i]) r = i;
        end
        return r;
    endfunction

    // Runs one frame with a 3-cycle EXPAND model. stray: pulse exp_done in SCAN
    // and flip ch_enable/ch_law mid-frame. ovr: inject frame_sync together with
    // overrun_clr while in WAIT. sup_ch: channel whose done is withheld.
    task automatic run_frame(input logic [31:0] en, input logic [31:0] law,
                             input bit stray, input bit ovr, input int sup_ch);
        logic [31:0] mask;
        int gap, dcnt, cyc, want, ovr_st, extra;
        bit skip_lat, toggled;
        mask = en; gap = 0; dcnt = 0; cyc = 0; ovr_st = 0;
        skip_lat = 1'b0; toggled = 1'b0;
        n_start = 0; n_fdone = 0;
        @(negedge clk);
        ch_enable = en; ch_law = law; frame_sync = 1'b1;
        while (n_fdone == 0 && cyc < 3000) begin
            @(negedge clk);
            gap++; cyc++;
            frame_sync = 1'b0; overrun_clr = 1'b0; exp_done = 1'b0;
            if (cyc == 1) check_val("busy_on", {31'd0, busy}, 32'd1);
            if (ovr_st == 1) begin
                check_val("ovr_set_wins", {31'd0, overrun}, 32'd1);
                ovr_st = 2;
            end
            if (stray && gap == 1) begin
                exp_done = 1'b1;
                if (!toggled) begin
                    ch_enable = ~en; ch_law = ~law; toggled = 1'b1;
                end
            end
            if (exp_start) begin
                want = lowest(mask);
                check_val("exp_ch", {27'd0, exp_ch}, want);
                if (want < 32) begin
                    check_val("exp_law", {31'd0, exp_law}, {31'd0, law[want]});
                    mask[want] = 1'b0;
                end
                if (!skip_lat) check_val("start_lat", gap, 32'd2);
                skip_lat = 1'b0;
                n_start++;
                if (int'(exp_ch) == sup_ch) skip_lat = 1'b1;
                else                        dcnt = DONE_DLY;
            end else if (dcnt > 0) begin
                dcnt--;
                if (ovr && ovr_st == 0 && dcnt == 2) begin
                    frame_sync = 1'b1; overrun_clr = 1'b1; ovr_st = 1;
                end
                if (dcnt == 0) begin
                    exp_done = 1'b1; gap = 0;
                end
            end
            if (frame_done) begin
                n_fdone++;
                if (!skip_lat) check_val("fdone_lat", gap, 32'd2);
            end
        end
        check_val("fdone_seen", n_fdone, 32'd1);
        check_val("n_start", n_start, $countones(en));
        @(negedge clk);
        exp_done = 1'b0;
        check_val("busy_off", {31'd0, busy}, 32'd0);
        extra = 0;
        for (int k = 0; k < 3; k++) begin
            if (exp_start || frame_done) extra++;
            @(negedge clk);
        end
        check_val("quiet_after", extra, 32'd0);
    endtask

    initial begin
        int extra;
        repeat (3) @(negedge clk);
        check_val("rst_exp_start", {31'd0, exp_start}, 32'd0);
        check_val("rst_exp_ch", {27'd0, exp_ch}, 32'd0);
        check_val("rst_exp_law", {31'd0, exp_law}, {31'd0, LAW_MU});
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check_val("rst_overrun", {31'd0, overrun}, 32'd0);
        check_val("rst_scan_out0", {31'd0, scan_out0}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic frame: channels 0 (mu) and 2 (A).
        run_frame(32'h0000_0005, 32'h0000_0004, 1'b0, 1'b0, -1);
        // Empty mask.
        run_frame(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, -1);
        // Full load.
        run_frame(32'hFFFF_FFFF, 32'hA5A5_0F0F, 1'b0, 1'b0, -1);
        // Overrun during WAIT; frame must complete unchanged.
        check_val("ovr_pre", {31'd0, overrun}, 32'd0);
        run_frame(32'h0000_0012, 32'h0000_0010, 1'b0, 1'b1, -1);
        check_val("ovr_sticky", {31'd0, overrun}, 32'd1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check_val("ovr_cleared", {31'd0, overrun}, 32'd0);
        // Snapshot and stray done.
        run_frame(32'h8000_0101, 32'h8000_0001, 1'b1, 1'b0, -1);

`ifdef EXPAND_SCHED_TIMEOUT_EN
        // Channel 3 never completes; scheduler abandons it and moves to 5.
        run_frame(32'h0000_0028, 32'h0000_0020, 1'b0, 1'b0, 3);
        check_val("err_timeout", {31'd0, err_timeout}, 32'd1);
        check_val("err_ch", {27'd0, err_ch}, 32'd3);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check_val("err_timeout_clr", {31'd0, err_timeout}, 32'd0);
`endif

        // Reset while in WAIT on channel 1 (A-law), with overrun set.
        @(negedge clk);
        ch_enable = 32'h0000_0006; ch_law = 32'h0000_0002; frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        @(negedge clk);
        check_val("mrst_start", {31'd0, exp_start}, 32'd1);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        check_val("mrst_pre_ch", {27'd0, exp_ch}, 32'd1);
        check_val("mrst_pre_law", {31'd0, exp_law}, {31'd0, LAW_A});
        check_val("mrst_pre_ovr", {31'd0, overrun}, 32'd1);
        reset = 1'b1;
        #1;
        check_val("mrst_exp_ch", {27'd0, exp_ch}, 32'd0);
        check_val("mrst_exp_law", {31'd0, exp_law}, 32'd0);
        check_val("mrst_busy", {31'd0, busy}, 32'd0);
        check_val("mrst_overrun", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (frame_done || busy || exp_start) extra++;
        end
        check_val("mrst_no_fdone", extra, 32'd0);

        // Recovery: a normal frame after the abandoned one.
        run_frame(32'h0000_0040, 32'h0000_0040, 1'b0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
